infix_seq_ctrl: RTL
===================

// Module: infix_seq_ctrl
// PURPOSE
// - Shunting-yard sequencer: accepts infix ASCII tokens and emits the postfix token stream.
// - Owns the operator stack and pop/push ordering.
// - Sits between the token source and the postfix evaluator stacks.
// - Replaces the free-running, unhandshaked infix->postfix conversion with valid/ready flow control on both sides.
// PARAMETERS
// - DEPTH  8  operator-stack entries (>=1)
// - LVL_W  $clog2(DEPTH+1)  width of level output
// PORTS
// - clk        in   1      single clock, rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - clr        in   1      sync clear: empty stack, drop out token, leave ERR, back to ACCEPT
// - in_valid   in   1      infix token valid
// - in_data    in   8      ASCII token; '+', '*', '=' are control, all else operands
// - in_ready   out  1      token accepted when in_valid && in_ready
// - out_valid  out  1      postfix token valid
// - out_data   out  8      postfix token
// - out_ready  in   1      sink takes token when out_valid && out_ready
// - done       out  1      1-cycle pulse when the trailing '=' is transferred out
// - err        out  1      sticky; set on stack overflow or paren error
// - level      out  LVL_W  current operator-stack occupancy
// BEHAVIOUR
// - Reset: state=ACCEPT, stack empty, out_valid=0, out_data=0, done=0, err=0, level=0.
// - Output register: one slot; out_data stable while out_valid && !out_ready.
// - Slot free = !out_valid || out_ready.
// - in_ready = (state==ACCEPT) && slot free.
// - Precedence: '*'=2, '+'=1, '('=0. Operators are left-assoc (pop while prec(top) >= prec(new)).
// - States:
// - ACCEPT, operand: latch operand to output; out_valid=1 next cycle (latency 1). Stay in ACCEPT.
// - ACCEPT, operator: latch it as pend, go POP.
// - ACCEPT, '=': go FLUSH.
// - POP: if stack nonempty && prec(top) >= prec(pend), emit top and pop, one per free-slot cycle.
// - POP: else push pend, return to ACCEPT.
// - POP: if push with level==DEPTH, set err, drop pend, go ERR.
// - POP: minimum op-to-op turnaround is 2 cycles.
// - FLUSH: emit and pop top each free-slot cycle until empty, then go EMIT_EQ.
// - EMIT_EQ: load '=' into slot. done pulses the cycle '=' is handed off. Go ACCEPT.
// - ERR: in_ready=0, out_valid=0. Exit only via clr or rst_n.
// - Stall: with slot not free, no push/pop/emit occurs; state holds.
// - clr && token handshake same cycle: clr wins, token lost.
// - '=' with empty stack: emits '=' only, after 1 FLUSH cycle.
// - Async reset mid-expression: all state, stack and slot discarded immediately.
// CONFIGURATION
// - INFIX_SEQ_PAREN_EN defined:
//   - '(' is pushed unconditionally and never emitted.
//   - ')' enters POP_PAREN: emit/pop until top=='(', then discard '(' (no emit).
//   - ')' with no '(' on stack sets err -> ERR.
//   - '=' with '(' remaining sets err -> ERR.
//   - '(' on full stack sets err -> ERR.
// - INFIX_SEQ_PAREN_EN undefined: '(' and ')' are plain operands, passed through with latency 1.
// TESTING
// - T1: "2+3*4=", out_ready=1 -> out "234*+=", done once, level peaks 2, err=0.
// - T2: "2*3+4=" -> out "23*4+=". '+' pops '*' before its own push.
// - T3: T1 with out_ready toggling 1/0 each cycle -> identical stream, no drops/dups, out_data stable while stalled.
// - T4: DEPTH=1, "2+3*" -> err=1 after '*' push attempt, in_ready=0.
// - T4 (cont.): then clr -> level=0, err=0, "5=" -> "5=".
// - T5: rst_n low after "1+2" accepted -> all outputs at reset values.
// - T5 (cont.): then "7*8=" -> "78*=".
// - T6 (PAREN_EN): "(2+3)*4=" -> "23+4*=".
// - T6 (cont.): ")=" -> err=1; "(1=" -> err=1.

Source files
------------

// File: rtl/infix_seq_ctrl.sv
// infix_seq_ctrl: shunting-yard sequencer. Takes infix ASCII tokens over valid/ready and
// emits the equivalent postfix token stream over valid/ready through a one-token output
// register. Owns the operator stack and its pop/push ordering.
//
// Optional feature macro: INFIX_SEQ_PAREN_EN
//   defined   : '(' / ')' are grouping operators handled on the stack
//   undefined : '(' / ')' are plain operands passed straight through
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr_i        synchronous clear (empties stack, drops slot token, leaves error state)
//   in_valid_i   infix token valid
//   in_data_i    ASCII token; '+', '*', '=' are control, all else operands
//   in_ready_o   token accepted when in_valid_i && in_ready_o
//   out_valid_o  postfix token valid
//   out_data_o   postfix token, stable while stalled
//   out_ready_i  sink takes token when out_valid_o && out_ready_i
//   done_o       pulses in the cycle the trailing '=' is handed off
//   err_o        sticky overflow / parenthesis error
//   level_o      operator-stack occupancy
module infix_seq_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [7:0]       out_data_o,
  input  logic             out_ready_i,
  output logic             done_o,
  output logic             err_o,
  output logic [LVL_W-1:0] level_o
);

  typedef enum logic [2:0] {
    StAccept,
    StPop,
    StFlush,
    StEmitEq,
    StErr,
    StPopParen
  } state_e;

  localparam logic [7:0] ChPlus = 8'h2B;
  localparam logic [7:0] ChMul  = 8'h2A;
  localparam logic [7:0] ChEq   = 8'h3D;
  localparam logic [7:0] ChLp   = 8'h28;
  localparam logic [7:0] ChRp   = 8'h29;

  localparam logic [LVL_W-1:0] LvlFull = LVL_W'(DEPTH);

  state_e           state_q;
  logic [7:0]       stack_q [DEPTH];
  logic [LVL_W-1:0] level_q;
  logic [7:0]       pend_q;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             err_q;

  logic       slot_free;
  logic       in_fire;
  logic       stk_empty;
  logic       stk_full;
  logic [7:0] top;

  function automatic logic [1:0] prec(input logic [7:0] c);
    logic [1:0] p;
    p = 2'd0;
    if (c == ChMul) p = 2'd2;
    else if (c == ChPlus) p = 2'd1;
    return p;
  endfunction

  // Entry level_q-1 is the top of stack; a loop avoids a zero-width index when DEPTH == 1.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (level_q == LVL_W'(i + 1)) top = stack_q[i];
    end
  end

  assign slot_free = !out_valid_q || out_ready_i;
  assign in_ready_o = (state_q == StAccept) && slot_free;
  assign in_fire = in_valid_i && in_ready_o;
  assign stk_empty = (level_q == '0);
  assign stk_full = (level_q == LvlFull);

  assign out_valid_o = out_valid_q;
  assign out_data_o = out_data_q;
  assign err_o = err_q;
  assign level_o = level_q;
  // Only EMIT_EQ ever loads '=' into the slot, so the data compare identifies it.
  assign done_o = out_valid_q && out_ready_i && (out_data_q == ChEq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccept;
      level_q     <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (clr_i) begin
      state_q     <= StAccept;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      // Slot empties on handoff; any load below in the same cycle overrides this.
      if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;

      unique case (state_q)
        StAccept: begin
          if (in_fire) begin
            if (in_data_i == ChPlus || in_data_i == ChMul) begin
              pend_q  <= in_data_i;
              state_q <= StPop;
            end else if (in_data_i == ChEq) begin
              state_q <= StFlush;
`ifdef INFIX_SEQ_PAREN_EN
            end else if (in_data_i == ChLp) begin
              if (stk_full) begin
                err_q   <= 1'b1;
                state_q <= StErr;
              end else begin
                for (int i = 0; i < DEPTH; i++) begin
                  if (level_q == LVL_W'(i)) stack_q[i] <= ChLp;
                end
                level_q <= level_q + LVL_W'(1);
              end
            end else if (in_data_i == ChRp) begin
              state_q <= StPopParen;
`endif
            end else begin
              out_data_q  <= in_data_i;
              out_valid_q <= 1'b1;
            end
          end
        end

        StPop: begin
          if (slot_free) begin
            if (!stk_empty && (prec(top) >= prec(pend_q))) begin
              out_data_q  <= top;
              out_valid_q <= 1'b1;
              level_q     <= level_q - LVL_W'(1);
            end else if (stk_full) begin
              err_q   <= 1'b1;
              state_q <= StErr;
            end else begin
              for (int i = 0; i < DEPTH; i++) begin
                if (level_q == LVL_W'(i)) stack_q[i] <= pend_q;
              end
              level_q <= level_q + LVL_W'(1);
              state_q <= StAccept;
            end
          end
        end

        StFlush: begin
          if (slot_free) begin
            if (stk_empty) begin
              state_q <= StEmitEq;
`ifdef INFIX_SEQ_PAREN_EN
            end else if (top == ChLp) begin
              // Unclosed '(' at end of expression.
              err_q   <= 1'b1;
              state_q <= StErr;
`endif
            end else begin
              out_data_q  <= top;
              out_valid_q <= 1'b1;
              level_q     <= level_q - LVL_W'(1);
            end
          end
        end

        StEmitEq: begin
          if (slot_free) begin
            out_data_q  <= ChEq;
            out_valid_q <= 1'b1;
            state_q     <= StAccept;
          end
        end

        StPopParen: begin
`ifdef INFIX_SEQ_PAREN_EN
          if (slot_free) begin
            if (stk_empty) begin
              err_q   <= 1'b1;
              state_q <= StErr;
            end else if (top == ChLp) begin
              level_q <= level_q - LVL_W'(1);
              state_q <= StAccept;
            end else begin
              out_data_q  <= top;
              out_valid_q <= 1'b1;
              level_q     <= level_q - LVL_W'(1);
            end
          end
`else
          state_q <= StAccept;
`endif
        end

        StErr: begin
          out_valid_q <= 1'b0;
        end

        default: begin
          state_q <= StAccept;
        end
      endcase
    end
  end

endmodule
